// File: rtl/dds_mc_pkg.sv
// Shared definitions for the multi-channel NCO/modulator: mode and config-select
// encodings, pipeline depth, and the quarter-wave sine table generator.
// No ports; imported by dds_qw_lut and dds_mc_mod.
package dds_mc_pkg;

  typedef enum logic [1:0] {
    MODE_CW   = 2'd0,
    MODE_ASK  = 2'd1,
    MODE_FSK  = 2'd2,
    MODE_BPSK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SEL_INC0 = 2'd0,
    SEL_INC1 = 2'd1,
    SEL_OFFS = 2'd2,
    SEL_RSVD = 2'd3
  } cfg_sel_e;

  // Registers from stage-0 input to the output flops.
  localparam int PIPE_DEPTH = 4;

  // Quarter-wave entry i. Sampling at (i+0.5) makes the table symmetric under
  // address inversion, so the mirrored quadrants reproduce the full wave exactly.
  function automatic int lut_value(input int idx, input int aw, input int mpr);
    real amp;
    real ang;
    amp = real'((1 << (mpr - 1)) - 1);
    ang = (3.14159265358979323846 / 2.0) * (real'(idx) + 0.5) / real'(1 << aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_qw_lut.sv
// Dual-read quarter-wave sine ROM (magnitude only, 0..2^(MPR-1)-1).
// Latency: 1 cycle, registered outputs. Backpressure: outputs hold while clken=0.
// Ports: clk, clken, addr_a/addr_b (AW bits) -> data_a/data_b (MPR-1 bits, unsigned).
module dds_qw_lut
  import dds_mc_pkg::*;
#(
  parameter int AW  = 10,
  parameter int MPR = 14
) (
  input  logic           clk,
  input  logic           clken,
  input  logic [AW-1:0]  addr_a,
  input  logic [AW-1:0]  addr_b,
  output logic [MPR-2:0] data_a,
  output logic [MPR-2:0] data_b
);

  logic [MPR-2:0] rom [2**AW];

  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    assign rom[i] = (MPR-1)'(lut_value(i, AW, MPR));
  end

  always_ff @(posedge clk) begin
    if (clken) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/dds_mc_mod.sv
// Time-multiplexed NCH-channel NCO with CW/ASK/FSK/BPSK modulation, quadrature output.
// Latency: slot entering stage 0 on enabled cycle n is on the outputs after cycle n+3.
// Backpressure: clken=0 freezes the pipeline (config still writable); out_valid drops.
// Ports: clk, reset_n, clken; cfg_wr/cfg_ch/cfg_sel/cfg_data (per-channel inc0, inc1,
//        offset); mod_mode (global), mod_data, sync_clr (per channel);
//        sin_o, cos_o (MPR-bit two's complement), ch_o, out_valid.
module dds_mc_mod
  import dds_mc_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int APR = 32,
  parameter  int AW  = 10,
  parameter  int MPR = 14,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            cfg_wr,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [1:0]      cfg_sel,
  input  logic [APR-1:0]  cfg_data,
  input  logic [1:0]      mod_mode,
  input  logic [NCH-1:0]  mod_data,
  input  logic [NCH-1:0]  sync_clr,
  output logic [MPR-1:0]  sin_o,
  output logic [MPR-1:0]  cos_o,
  output logic [CW-1:0]   ch_o,
  output logic            out_valid
);

  localparam logic [APR-1:0] PH_HALF = {1'b1, {(APR-1){1'b0}}};

  // Per-channel state
  logic [APR-1:0] acc  [NCH];
  logic [APR-1:0] inc0 [NCH];
  logic [APR-1:0] inc1 [NCH];
  logic [APR-1:0] offs [NCH];
  logic [CW-1:0]  slot;

  // Stage 0 combinational
  logic           sym0;
  logic [APR-1:0] acc_cur;
  logic [APR-1:0] inc_sel;
  logic [APR-1:0] ph0_nxt;
  logic           kill0;

  // Pipeline registers
  logic [APR-1:0] ph_s0;
  logic [CW-1:0]  ch_s0, ch_s1, ch_s2;
  logic           kill_s0, kill_s1, kill_s2;
  logic [1:0]     q_s1, q_s2;
  logic [AW-1:0]  a_s1;
  logic [PIPE_DEPTH-2:0] vld_sr;

  logic [AW-1:0]  addr_sin, addr_cos;
  logic [MPR-2:0] mag_sin, mag_cos;
  logic [MPR-1:0] sin_nxt, cos_nxt;

  // Phase bits below the LUT address only feed the carry chain.
  logic [APR-AW-3:0] unused_ph_lo;
  assign unused_ph_lo = ph_s0[APR-AW-3:0];

  always_comb begin
    sym0    = mod_data[slot];
    acc_cur = acc[slot];
    inc_sel = (mod_mode == MODE_FSK && sym0) ? inc1[slot] : inc0[slot];
    ph0_nxt = acc_cur + offs[slot];
    if (mod_mode == MODE_BPSK && sym0)
      ph0_nxt = ph0_nxt + PH_HALF;
    // A clear forces the whole emitted phase to zero, offset and BPSK included.
    if (sync_clr[slot])
      ph0_nxt = '0;
    kill0 = (mod_mode == MODE_ASK) && !sym0;
  end

  // Config registers ignore clken; a same-cycle write to the stage-0 channel
  // takes effect from that channel's next slot because reads above are of the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        inc0[i] <= '0;
        inc1[i] <= '0;
        offs[i] <= '0;
      end
    end else if (cfg_wr) begin
      case (cfg_sel)
        SEL_INC0: inc0[cfg_ch] <= cfg_data;
        SEL_INC1: inc1[cfg_ch] <= cfg_data;
        SEL_OFFS: offs[cfg_ch] <= cfg_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (clken) begin
      acc[slot] <= sync_clr[slot] ? '0 : acc_cur + inc_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot    <= '0;
      ph_s0   <= '0;
      ch_s0   <= '0;
      kill_s0 <= 1'b0;
      q_s1    <= '0;
      a_s1    <= '0;
      ch_s1   <= '0;
      kill_s1 <= 1'b0;
      q_s2    <= '0;
      ch_s2   <= '0;
      kill_s2 <= 1'b0;
      vld_sr  <= '0;
    end else if (clken) begin
      slot    <= (slot == CW'(NCH - 1)) ? '0 : slot + 1'b1;
      ph_s0   <= ph0_nxt;
      ch_s0   <= slot;
      kill_s0 <= kill0;
      q_s1    <= ph_s0[APR-1:APR-2];
      a_s1    <= ph_s0[APR-3:APR-2-AW];
      ch_s1   <= ch_s0;
      kill_s1 <= kill_s0;
      q_s2    <= q_s1;
      ch_s2   <= ch_s1;
      kill_s2 <= kill_s1;
      vld_sr  <= {vld_sr[PIPE_DEPTH-3:0], 1'b1};
    end
  end

  // Odd quadrants run the quarter wave backwards; cos is sin shifted one quadrant.
  assign addr_sin = q_s1[0] ? ~a_s1 : a_s1;
  assign addr_cos = q_s1[0] ? a_s1 : ~a_s1;

  dds_qw_lut #(
    .AW  (AW),
    .MPR (MPR)
  ) u_lut (
    .clk    (clk),
    .clken  (clken),
    .addr_a (addr_sin),
    .addr_b (addr_cos),
    .data_a (mag_sin),
    .data_b (mag_cos)
  );

  always_comb begin
    sin_nxt = q_s2[1]            ? -{1'b0, mag_sin} : {1'b0, mag_sin};
    cos_nxt = (q_s2[1] ^ q_s2[0]) ? -{1'b0, mag_cos} : {1'b0, mag_cos};
    if (kill_s2) begin
      sin_nxt = '0;
      cos_nxt = '0;
    end
  end

  // The ROM has no reset, so until the pipeline has filled the outputs load zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_o     <= '0;
      cos_o     <= '0;
      ch_o      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= clken & vld_sr[PIPE_DEPTH-2];
      if (clken) begin
        sin_o <= vld_sr[PIPE_DEPTH-2] ? sin_nxt : '0;
        cos_o <= vld_sr[PIPE_DEPTH-2] ? cos_nxt : '0;
        ch_o  <= vld_sr[PIPE_DEPTH-2] ? ch_s2   : '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_mc_mod.sv
// Self-checking bench for dds_mc_mod (NCH=4, APR=32, AW=10, MPR=14): directed vector
// table, hand-written corner sequences and a randomized run against a reference model.
module tb_dds_mc_mod;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic [1:0]  mod_mode;
  logic [3:0]  mod_data;
  logic [3:0]  sync_clr;
  logic [13:0] sin_o;
  logic [13:0] cos_o;
  logic [1:0]  ch_o;
  logic        out_valid;

  dds_mc_mod #(.NCH(4), .APR(32), .AW(10), .MPR(14)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .mod_mode  (mod_mode),
    .mod_data  (mod_data),
    .sync_clr  (sync_clr),
    .sin_o     (sin_o),
    .cos_o     (cos_o),
    .ch_o      (ch_o),
    .out_valid (out_valid)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_acc [4];
  logic [31:0] m_inc0[4];
  logic [31:0] m_inc1[4];
  logic [31:0] m_off [4];
  int m_slot, m_en;
  int pq_s[$], pq_c[$], pq_ch[$];
  int m_sin, m_cos, m_ch;
  bit m_vld;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  // Ideal wave sampled at the centre of the 4096-step phase bin containing p.
  function automatic int ref_wave(input logic [31:0] p, input bit want_cos);
    real th;
    th = 2.0 * PI * (real'(p >> 20) + 0.5) / 4096.0;
    return want_cos ? rnd(8191.0 * $cos(th)) : rnd(8191.0 * $sin(th));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_inc0[i] = 0; m_inc1[i] = 0; m_off[i] = 0;
    end
    m_slot = 0; m_en = 0;
    pq_s.delete(); pq_c.delete(); pq_ch.delete();
    m_sin = 0; m_cos = 0; m_ch = 0; m_vld = 0;
  endtask

  task automatic model_edge();
    int s, es, ec;
    bit d;
    logic [31:0] p;
    if (clken) begin
      s = m_slot;
      d = mod_data[s];
      if (sync_clr[s]) begin
        p = 0;
        m_acc[s] = 0;
      end else begin
        p = m_acc[s] + m_off[s] + ((mod_mode == 2'd3 && d) ? 32'h8000_0000 : 32'h0);
        m_acc[s] = m_acc[s] + ((mod_mode == 2'd2 && d) ? m_inc1[s] : m_inc0[s]);
      end
      es = ref_wave(p, 1'b0);
      ec = ref_wave(p, 1'b1);
      if (mod_mode == 2'd1 && !d) begin es = 0; ec = 0; end
      pq_s.push_back(es); pq_c.push_back(ec); pq_ch.push_back(s);
      if (pq_s.size() == 4) begin
        m_sin = pq_s.pop_front(); m_cos = pq_c.pop_front(); m_ch = pq_ch.pop_front();
      end
      m_slot = (m_slot + 1) % 4;
      if (m_en < 4) m_en++;
      m_vld = (m_en >= 4);
    end else begin
      m_vld = 0;
    end
    if (cfg_wr) begin
      case (cfg_sel)
        2'd0: m_inc0[cfg_ch] = cfg_data;
        2'd1: m_inc1[cfg_ch] = cfg_data;
        2'd2: m_off[cfg_ch]  = cfg_data;
        default: ;
      endcase
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("mdl_valid", int'(out_valid), int'(m_vld));
    check("mdl_ch", int'(ch_o), m_ch);
    check("mdl_sin", int'($signed(sin_o)), m_sin);
    check("mdl_cos", int'($signed(cos_o)), m_cos);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_sin", int'($signed(sin_o)), 0);
    check("rst_cos", int'($signed(cos_o)), 0);
    check("rst_ch", int'(ch_o), 0);
    check("rst_valid", int'(out_valid), 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic [31:0] data);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = data;
    tick();
    cfg_wr = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          ch;
    logic [31:0] inc0, inc1, off;
    logic [1:0]  mode;
    logic [3:0]  md;
    int          es[4];
    int          ec[4];
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  task automatic set_vec(input int i, input int ch, input logic [31:0] inc0,
                         input logic [31:0] inc1, input logic [31:0] off,
                         input logic [1:0] mode, input logic [3:0] md,
                         input int s0, input int s1, input int s2, input int s3,
                         input int c0, input int c1, input int c2, input int c3);
    vt[i].ch = ch; vt[i].inc0 = inc0; vt[i].inc1 = inc1; vt[i].off = off;
    vt[i].mode = mode; vt[i].md = md;
    vt[i].es[0] = s0; vt[i].es[1] = s1; vt[i].es[2] = s2; vt[i].es[3] = s3;
    vt[i].ec[0] = c0; vt[i].ec[1] = c1; vt[i].ec[2] = c2; vt[i].ec[3] = c3;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int clr_s[3];
    int clr_c[3];
    reset_n = 1'b0; clken = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_sel = '0;
    cfg_data = '0; mod_mode = '0; mod_data = '0; sync_clr = '0;
    model_reset();

    //      idx ch inc0          inc1          off           mode md     sin                 cos
    set_vec(0, 0, 32'h4000_0000, 32'h0,        32'h0,        2'd0, 4'h0, 6, 8191, -6, -8191, 8191, -6, -8191, 6);
    set_vec(1, 1, 32'h0,         32'h0,        32'h8000_0000, 2'd0, 4'h0, -6, -6, -6, -6, -8191, -8191, -8191, -8191);
    set_vec(2, 0, 32'h4000_0000, 32'h8000_0000, 32'h0,       2'd2, 4'hF, 6, -6, 6, -6, 8191, -8191, 8191, -8191);
    set_vec(3, 0, 32'h4000_0000, 32'h0,        32'h0,        2'd3, 4'hF, -6, -8191, 6, 8191, -8191, 6, 8191, -6);
    set_vec(4, 2, 32'h4000_0000, 32'h0,        32'h0,        2'd1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(5, 2, 32'h4000_0000, 32'h0,        32'h0,        2'd1, 4'hF, 6, 8191, -6, -8191, 8191, -6, -8191, 6);
    set_vec(6, 3, 32'h0,         32'h0,        32'h0,        2'd0, 4'h0, 6, 6, 6, 6, 8191, 8191, 8191, 8191);
    set_vec(7, 1, 32'h4000_0000, 32'h8000_0000, 32'h0,       2'd2, 4'h0, 6, 8191, -6, -8191, 8191, -6, -8191, 6);

    #1;
    for (int v = 0; v < NV; v++) begin
      clken = 1'b0; mod_mode = 2'd0; mod_data = 4'h0;
      do_reset();
      // Configure while frozen so the first enabled slot (ch0) already sees it.
      cfg_write(vt[v].ch, 0, vt[v].inc0);
      cfg_write(vt[v].ch, 1, vt[v].inc1);
      cfg_write(vt[v].ch, 2, vt[v].off);
      mod_mode = vt[v].mode; mod_data = vt[v].md;
      clken = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 64 && got < 4; cyc++) begin
        tick();
        if (cyc < 6) check($sformatf("vec%0d_valid_c%0d", v, cyc), int'(out_valid), int'(cyc >= 3));
        if (out_valid && int'(ch_o) == vt[v].ch) begin
          check($sformatf("vec%0d_sin%0d", v, got), int'($signed(sin_o)), vt[v].es[got]);
          check($sformatf("vec%0d_cos%0d", v, got), int'($signed(cos_o)), vt[v].ec[got]);
          got++;
        end
      end
      check($sformatf("vec%0d_samples", v), got, 4);
    end

    // sync_clr: a pulse outside the ch0 slot is ignored, one inside restarts ch0.
    clken = 1'b0; mod_mode = 2'd0; mod_data = 4'h0;
    do_reset();
    cfg_write(0, 0, 32'h4000_0000);
    clken = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 8 && m_slot != 2; i++) tick();
    sync_clr = 4'b0001;
    tick();
    sync_clr = 4'b0000;
    for (int i = 0; i < 8 && m_slot != 0; i++) tick();
    sync_clr = 4'b0001;
    tick();
    sync_clr = 4'b0000;
    clr_s = '{6, 6, 8191};
    clr_c = '{8191, 8191, -6};
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      tick();
      if (out_valid && ch_o == 2'd0) begin
        check($sformatf("clr_sin%0d", got), int'($signed(sin_o)), clr_s[got]);
        check($sformatf("clr_cos%0d", got), int'($signed(cos_o)), clr_c[got]);
        got++;
      end
    end
    check("clr_samples", got, 3);

    // Freeze for 5 cycles mid-stream, resume, then reset while running.
    repeat (3) tick();
    clken = 1'b0;
    repeat (5) tick();
    clken = 1'b1;
    repeat (12) tick();
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if ($urandom_range(0, 29) == 0) mod_mode = 2'($urandom_range(0, 3));
      mod_data = 4'($urandom);
      sync_clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      clken    = ($urandom_range(0, 9) != 0);
      cfg_wr   = ($urandom_range(0, 5) == 0);
      cfg_ch   = 2'($urandom);
      cfg_sel  = 2'($urandom);
      cfg_data = ($urandom_range(0, 1) == 1) ? {2'($urandom), 30'h0} : $urandom;
      tick();
    end
    cfg_wr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
